// File: rtl/imu_frame_assembler.sv
// Turns the 14-byte MPU6050 burst into signed 24-bit axis values, removing the
// gyro zero-rate bias learned from the first 2^CAL_SHIFT complete frames.
module imu_frame_assembler #(
  parameter int CAL_SHIFT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [23:0] cur_pitch_gyro,
  output logic [23:0] cur_roll_gyro,
  output logic [23:0] cur_yaw_gyro,
  output logic [23:0] cur_pitch_acc,
  output logic [23:0] cur_roll_acc,
  output logic        cmp_filter_en,
  output logic        cal_done,
  output logic        frame_err
);

  localparam int ACC_W = 16 + CAL_SHIFT;

  typedef enum logic {CAL, RUN} state_t;

  state_t                 state;
  logic [3:0]             byte_cnt;
  logic [15:0]            words [0:7];
  logic                   frame_done;
  logic [CAL_SHIFT-1:0]   frame_cnt;
  logic [ACC_W-1:0]       acc_x, acc_y, acc_z;
  logic [ACC_W-1:0]       sum_x, sum_y, sum_z;
  logic [15:0]            off_x, off_y, off_z;
  logic [15:0]            accel_x, accel_y, gyro_x, gyro_y, gyro_z;

  assign accel_x = words[0];
  assign accel_y = words[1];
  assign gyro_x  = words[4];
  assign gyro_y  = words[5];
  assign gyro_z  = words[6];

  always_comb begin
    sum_x = acc_x + {{CAL_SHIFT{gyro_x[15]}}, gyro_x};
    sum_y = acc_y + {{CAL_SHIFT{gyro_y[15]}}, gyro_y};
    sum_z = acc_z + {{CAL_SHIFT{gyro_z[15]}}, gyro_z};
  end

  // Byte capture runs at edge N; frame_done delays the frame-level work to edge N+1,
  // which lets a new frame start at N+1 without disturbing the values being consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= CAL;
      byte_cnt       <= 4'd14;
      frame_done     <= 1'b0;
      frame_cnt      <= '0;
      acc_x          <= '0;
      acc_y          <= '0;
      acc_z          <= '0;
      off_x          <= '0;
      off_y          <= '0;
      off_z          <= '0;
      cur_pitch_gyro <= '0;
      cur_roll_gyro  <= '0;
      cur_yaw_gyro   <= '0;
      cur_pitch_acc  <= '0;
      cur_roll_acc   <= '0;
      cmp_filter_en  <= 1'b0;
      cal_done       <= 1'b0;
      frame_err      <= 1'b0;
      for (int i = 0; i < 8; i++) words[i] <= '0;
    end else begin
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      cmp_filter_en <= 1'b0;

      if (frame_start) begin
        if (byte_cnt != 4'd0 && byte_cnt != 4'd14) frame_err <= 1'b1;
        if (byte_valid) begin
          words[0][15:8] <= byte_data;
          byte_cnt       <= 4'd1;
        end else begin
          byte_cnt       <= 4'd0;
        end
      end else if (byte_valid && byte_cnt < 4'd14) begin
        if (byte_cnt[0]) words[byte_cnt[3:1]][7:0]  <= byte_data;
        else             words[byte_cnt[3:1]][15:8] <= byte_data;
        byte_cnt <= byte_cnt + 4'd1;
        if (byte_cnt == 4'd13) frame_done <= 1'b1;
      end

      // Offsets are the top 16 bits of the final sum, i.e. an arithmetic shift by CAL_SHIFT.
      if (frame_done) begin
        case (state)
          CAL: begin
            acc_x     <= sum_x;
            acc_y     <= sum_y;
            acc_z     <= sum_z;
            frame_cnt <= frame_cnt + 1'b1;
            if (frame_cnt == '1) begin
              off_x    <= sum_x[ACC_W-1:CAL_SHIFT];
              off_y    <= sum_y[ACC_W-1:CAL_SHIFT];
              off_z    <= sum_z[ACC_W-1:CAL_SHIFT];
              cal_done <= 1'b1;
              state    <= RUN;
            end
          end
          RUN: begin
            cur_pitch_gyro <= {{8{gyro_x[15]}}, gyro_x} - {{8{off_x[15]}}, off_x};
            cur_roll_gyro  <= {{8{gyro_y[15]}}, gyro_y} - {{8{off_y[15]}}, off_y};
            cur_yaw_gyro   <= {{8{gyro_z[15]}}, gyro_z} - {{8{off_z[15]}}, off_z};
            cur_pitch_acc  <= {{8{accel_y[15]}}, accel_y};
            cur_roll_acc   <= 24'd0 - {{8{accel_x[15]}}, accel_x};
            cmp_filter_en  <= 1'b1;
          end
          default: state <= CAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imu_frame_assembler.sv
// Self-checking bench for imu_frame_assembler: table-driven RUN frames checked through
// a scoreboard, plus hand-written calibration, partial-frame and reset sequences.
module tb_imu_frame_assembler;

  localparam int NCAL = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic [23:0] cur_pitch_gyro, cur_roll_gyro, cur_yaw_gyro, cur_pitch_acc, cur_roll_acc;
  logic        cmp_filter_en, cal_done, frame_err;

  imu_frame_assembler #(.CAL_SHIFT(6)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .cur_pitch_gyro(cur_pitch_gyro), .cur_roll_gyro(cur_roll_gyro),
    .cur_yaw_gyro(cur_yaw_gyro), .cur_pitch_acc(cur_pitch_acc), .cur_roll_acc(cur_roll_acc),
    .cmp_filter_en(cmp_filter_en), .cal_done(cal_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] gx, gy, gz, ax, ay;
    logic [23:0] pg, rg, yg, pa, ra;
  } vec_t;

  typedef struct {
    logic [23:0] pg, rg, yg, pa, ra;
  } exp_t;

  vec_t vecs [5];
  exp_t sb [$];
  exp_t lastExp;
  int   checks = 0;
  int   errors = 0;
  int   errPulses = 0;
  logic prevEn = 1'b0;

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%06h, expected 0x%06h", name, act, expv);
    end
  endtask

  // Every strobe is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && frame_err) errPulses++;
    if (rst_n && cmp_filter_en) begin
      if (prevEn) begin
        errors++; checks++;
        $display("[TB] FAIL strobe_back_to_back: got 2 consecutive cycles, expected 1");
      end
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("[TB] FAIL unexpected_strobe: got strobe, expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("pitch_gyro", cur_pitch_gyro, e.pg);
        checkOutput("roll_gyro",  cur_roll_gyro,  e.rg);
        checkOutput("yaw_gyro",   cur_yaw_gyro,   e.yg);
        checkOutput("pitch_acc",  cur_pitch_acc,  e.pa);
        checkOutput("roll_acc",   cur_roll_acc,   e.ra);
      end
    end
    prevEn = rst_n && cmp_filter_en;
  end

  function automatic logic [6:0][15:0] buildWords(input logic [15:0] gx, gy, gz, ax, ay);
    logic [6:0][15:0] w;
    w[0] = ax; w[1] = ay; w[2] = 16'h4000; w[3] = 16'h0BAD;
    w[4] = gx; w[5] = gy; w[6] = gz;
    return w;
  endfunction

  // Drives bytes first..last; returns #1 after the edge that accepts the last one.
  task automatic sendBytes(input logic [6:0][15:0] w, input int first, input int last,
                           input bit withStart, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        frame_start = 1'b0; byte_valid = 1'b0;
      end
      @(posedge clk); #1;
      frame_start = withStart && (i == first);
      byte_valid  = 1'b1;
      byte_data   = i[0] ? w[i/2][7:0] : w[i/2][15:8];
    end
    @(posedge clk); #1;
    frame_start = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input bit gaps);
    exp_t e;
    e.pg = v.pg; e.rg = v.rg; e.yg = v.yg; e.pa = v.pa; e.ra = v.ra;
    sb.push_back(e);
    lastExp = e;
    sendBytes(buildWords(v.gx, v.gy, v.gz, v.ax, v.ay), 0, 13, 1'b1, gaps);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0; frame_start = 1'b0; byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic checkResetState();
    checkOutput("rst_pitch_gyro", cur_pitch_gyro, 24'h0);
    checkOutput("rst_roll_gyro",  cur_roll_gyro,  24'h0);
    checkOutput("rst_yaw_gyro",   cur_yaw_gyro,   24'h0);
    checkOutput("rst_pitch_acc",  cur_pitch_acc,  24'h0);
    checkOutput("rst_roll_acc",   cur_roll_acc,   24'h0);
    checkOutput("rst_strobe",     {23'h0, cmp_filter_en}, 24'h0);
    checkOutput("rst_cal_done",   {23'h0, cal_done},      24'h0);
    checkOutput("rst_frame_err",  {23'h0, frame_err},     24'h0);
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, "_pitch_gyro"}, cur_pitch_gyro, lastExp.pg);
    checkOutput({tag, "_roll_gyro"},  cur_roll_gyro,  lastExp.rg);
    checkOutput({tag, "_yaw_gyro"},   cur_yaw_gyro,   lastExp.yg);
    checkOutput({tag, "_pitch_acc"},  cur_pitch_acc,  lastExp.pa);
    checkOutput({tag, "_roll_acc"},   cur_roll_acc,   lastExp.ra);
  endtask

  function automatic int floorDiv64(input int s);
    if (s >= 0) return s / 64;
    return -((-s + 63) / 64);
  endfunction

  initial begin
    int sx, sy, sz, ox, oy, oz, ep;
    logic [15:0] gx, gy, gz;
    logic [6:0][15:0] w;
    exp_t e;

    // Offsets after the first calibration are 100, -100, 16.
    vecs[0] = '{16'h00C8, 16'h0000, 16'h0010, 16'h1000, 16'hF000,
                24'h000064, 24'h000064, 24'h000000, 24'hFFF000, 24'hFFF000};
    vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF,
                24'h007F9B, 24'h008063, 24'hFF7FF0, 24'h007FFF, 24'h008000};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h8000,
                24'hFF7F9C, 24'hFF8064, 24'hFFFFF0, 24'hFF8000, 24'hFF8001};
    vecs[3] = '{16'h0064, 16'hFF9C, 16'h0010, 16'h0001, 16'h0001,
                24'h000000, 24'h000000, 24'h000000, 24'h000001, 24'hFFFFFF};
    vecs[4] = '{16'h1234, 16'hFFFF, 16'h000F, 16'h0000, 16'h00FF,
                24'h0011D0, 24'h000063, 24'hFFFFFF, 24'h0000FF, 24'h000000};

    doReset();
    checkResetState();

    // Bytes before the first frame_start must not form a frame.
    sendBytes(buildWords(16'h7000, 16'h7000, 16'h7000, 16'h0, 16'h0), 0, 13, 1'b0, 1'b0);

    for (int f = 0; f < NCAL; f++) begin
      sendBytes(buildWords(16'h0064, 16'hFF9C, 16'h0010, 16'h1111, 16'h2222), 0, 13, 1'b1, f[0]);
      if (f == NCAL - 1)
        checkOutput("cal_done_before_rise", {23'h0, cal_done}, 24'h0);
    end
    @(posedge clk); #1;
    checkOutput("cal_done_rise", {23'h0, cal_done}, 24'h1);
    checkOutput("cal_no_output", cur_pitch_gyro, 24'h0);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i[0]);

    // Partial frame: 7 bytes then a bare frame_start.
    ep = errPulses;
    sendBytes(buildWords(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 16'h0EEE), 0, 6, 1'b1, 1'b0);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    checkOutput("frame_err_pulse", {23'h0, frame_err}, 24'h1);
    @(posedge clk); #1;
    checkOutput("frame_err_single", {23'h0, frame_err}, 24'h0);
    repeat (3) @(posedge clk); #1;
    checkHeld("partial_held");
    applyStimulus(vecs[0], 1'b0);
    checkOutput("partial_err_count", 24'(errPulses - ep), 24'd1);

    // frame_start arriving together with what would have been byte 13.
    ep = errPulses;
    sendBytes(buildWords(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 16'h0EEE), 0, 12, 1'b1, 1'b0);
    applyStimulus(vecs[2], 1'b0);
    checkOutput("coincident_err_count", 24'(errPulses - ep), 24'd1);

    // Surplus bytes after a complete frame are ignored.
    ep = errPulses;
    sendBytes(buildWords(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 16'h0EEE), 0, 13, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    checkHeld("surplus_held");
    checkOutput("surplus_no_err", 24'(errPulses - ep), 24'd0);

    // Reset mid-calibration: only post-reset frames may contribute.
    doReset();
    checkResetState();
    for (int f = 0; f < 30; f++)
      sendBytes(buildWords(16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0), 0, 13, 1'b1, 1'b0);
    sendBytes(buildWords(16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0), 0, 6, 1'b1, 1'b0);
    doReset();
    checkResetState();
    sx = 0; sy = 0; sz = 0;
    for (int f = 0; f < NCAL; f++) begin
      gx = 16'(16'h0100 + f);
      gy = 16'(-(f * 3) - 5);
      gz = f[0] ? 16'h8000 : 16'h7FFF;
      sx += int'($signed(gx)); sy += int'($signed(gy)); sz += int'($signed(gz));
      sendBytes(buildWords(gx, gy, gz, 16'h0, 16'h0), 0, 13, 1'b1, 1'b0);
      if (f == NCAL - 2) begin
        @(posedge clk); #1;
        checkOutput("recal_not_done", {23'h0, cal_done}, 24'h0);
      end
    end
    @(posedge clk); #1;
    checkOutput("recal_done", {23'h0, cal_done}, 24'h1);
    ox = floorDiv64(sx); oy = floorDiv64(sy); oz = floorDiv64(sz);
    e.pg = 24'(-ox); e.rg = 24'(-oy); e.yg = 24'(-oz); e.pa = 24'h0; e.ra = 24'h0;
    sb.push_back(e);
    w = buildWords(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    sendBytes(w, 0, 13, 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;

    checkOutput("scoreboard_drained", 24'(sb.size()), 24'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
